// File: rtl/shifter_arbiter.sv
// shifter_arbiter: two-requester arbiter that feeds one external barrel shifter and returns a registered result with one-cycle ack
module shifter_arbiter #(
  parameter int WIDTH = 8,
  parameter int SHAMT_W = 3,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [WIDTH-1:0]   in0,
  input  logic [SHAMT_W-1:0] shamt0,
  input  logic               dir0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   in1,
  input  logic [SHAMT_W-1:0] shamt1,
  input  logic               dir1,
  output logic               ack0,
  output logic               ack1,
  output logic [WIDTH-1:0]   res,
  output logic               busy,
  output logic [WIDTH-1:0]   sh_in,
  output logic [SHAMT_W-1:0] sh_shamt,
  output logic               sh_dir,
  input  logic [WIDTH-1:0]   sh_out
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state_q, state_d;
  logic grant, pick, last_q, last_d;
  logic [WIDTH-1:0] sh_in_q, sh_in_d, res_q, res_d;
  logic [SHAMT_W-1:0] sh_shamt_q, sh_shamt_d;
  logic sh_dir_q, sh_dir_d, ack0_q, ack0_d, ack1_q, ack1_d;
  always_comb begin
    grant = state_q == IDLE && (req0 || req1);
    pick = FIXED_PRIO ? !req0 : (req0 && req1 ? !last_q : req1);
    state_d = grant ? EXEC : (state_q == EXEC ? DONE : IDLE);
    last_d = grant ? pick : last_q;
    sh_in_d = grant ? (pick ? in1 : in0) : sh_in_q;
    sh_shamt_d = grant ? (pick ? shamt1 : shamt0) : sh_shamt_q;
    sh_dir_d = grant ? (pick ? dir1 : dir0) : sh_dir_q;
    res_d = state_q == EXEC ? sh_out : res_q;
    ack0_d = state_q == EXEC && !last_q;
    ack1_d = state_q == EXEC && last_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      sh_in_q <= '0;
      sh_shamt_q <= '0;
      sh_dir_q <= 1'b0;
      res_q <= '0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      sh_in_q <= sh_in_d;
      sh_shamt_q <= sh_shamt_d;
      sh_dir_q <= sh_dir_d;
      res_q <= res_d;
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
    end
  end
  assign ack0 = ack0_q;
  assign ack1 = ack1_q;
  assign res = res_q;
  assign busy = state_q != IDLE;
  assign sh_in = sh_in_q;
  assign sh_shamt = sh_shamt_q;
  assign sh_dir = sh_dir_q;
endmodule

// File: tb/tb_shifter_arbiter.sv
// tb_shifter_arbiter: directed checks of both arbitration modes against a behavioural shifter
module tb_shifter_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 0, dir0 = 0, req1 = 0, dir1 = 0;
  logic [7:0] in0 = 0, in1 = 0;
  logic [2:0] shamt0 = 0, shamt1 = 0;
  logic ack0, ack1, busy, sh_dir;
  logic [7:0] res, sh_in, sh_out;
  logic [2:0] sh_shamt;
  logic b_req0 = 0, b_dir0 = 0, b_req1 = 0, b_dir1 = 0;
  logic [7:0] b_in0 = 0, b_in1 = 0;
  logic [2:0] b_shamt0 = 0, b_shamt1 = 0;
  logic b_ack0, b_ack1, b_busy, b_sh_dir;
  logic [7:0] b_res, b_sh_in, b_sh_out;
  logic [2:0] b_sh_shamt;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  assign sh_out = sh_dir ? sh_in << sh_shamt : sh_in >> sh_shamt;
  assign b_sh_out = b_sh_dir ? b_sh_in << b_sh_shamt : b_sh_in >> b_sh_shamt;
  shifter_arbiter #(.WIDTH(8), .SHAMT_W(3), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .in0(in0), .shamt0(shamt0), .dir0(dir0),
    .req1(req1), .in1(in1), .shamt1(shamt1), .dir1(dir1),
    .ack0(ack0), .ack1(ack1), .res(res), .busy(busy),
    .sh_in(sh_in), .sh_shamt(sh_shamt), .sh_dir(sh_dir), .sh_out(sh_out));
  shifter_arbiter #(.WIDTH(8), .SHAMT_W(3), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0(b_req0), .in0(b_in0), .shamt0(b_shamt0), .dir0(b_dir0),
    .req1(b_req1), .in1(b_in1), .shamt1(b_shamt1), .dir1(b_dir1),
    .ack0(b_ack0), .ack1(b_ack1), .res(b_res), .busy(b_busy),
    .sh_in(b_sh_in), .sh_shamt(b_sh_shamt), .sh_dir(b_sh_dir), .sh_out(b_sh_out));

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({ack0, ack1, busy, res, sh_in, sh_shamt, sh_dir} !== 22'h0) begin
      fails++;
      $display("FAIL reset_rr: got ack=%b%b busy=%b res=%h sh=%h/%0d/%b, want all 0", ack1, ack0, busy, res, sh_in, sh_shamt, sh_dir);
    end
    tests++;
    if ({b_ack0, b_ack1, b_busy, b_res, b_sh_in, b_sh_shamt, b_sh_dir} !== 22'h0) begin
      fails++;
      $display("FAIL reset_fp: got ack=%b%b busy=%b res=%h, want all 0", b_ack1, b_ack0, b_busy, b_res);
    end
    rst = 1'b0;
  endtask

  task automatic test_right_shift();
    req0 = 1; in0 = 8'hB4; shamt0 = 3'd2; dir0 = 0;
    @(negedge clk);
    tests++;
    if ({sh_in, sh_shamt, sh_dir, busy, ack0, ack1} !== {8'hB4, 3'd2, 1'b0, 1'b1, 2'b00}) begin
      fails++;
      $display("FAIL right_grant: got sh_in=%h shamt=%0d dir=%b busy=%b ack=%b%b, want B4/2/0 busy=1 ack=00", sh_in, sh_shamt, sh_dir, busy, ack1, ack0);
    end
    @(negedge clk);
    tests++;
    if ({res, busy, ack0, ack1} !== {8'h2D, 1'b1, 2'b10}) begin
      fails++;
      $display("FAIL right_ack: got res=%h busy=%b ack0=%b ack1=%b, want 2D busy=1 ack0=1 ack1=0", res, busy, ack0, ack1);
    end
    req0 = 0;
    @(negedge clk);
    tests++;
    if ({res, busy, ack0, ack1} !== {8'h2D, 1'b0, 2'b00}) begin
      fails++;
      $display("FAIL right_idle: got res=%h busy=%b ack=%b%b, want 2D busy=0 ack=00", res, busy, ack1, ack0);
    end
  endtask

  task automatic test_left_shift();
    req1 = 1; in1 = 8'h81; shamt1 = 3'd1; dir1 = 1;
    @(negedge clk);
    tests++;
    if ({sh_in, sh_shamt, sh_dir, ack0, ack1} !== {8'h81, 3'd1, 1'b1, 2'b00}) begin
      fails++;
      $display("FAIL left_grant: got sh_in=%h shamt=%0d dir=%b ack=%b%b, want 81/1/1 ack=00", sh_in, sh_shamt, sh_dir, ack1, ack0);
    end
    @(negedge clk);
    tests++;
    if ({res, ack0, ack1} !== {8'h02, 2'b01}) begin
      fails++;
      $display("FAIL left_ack: got res=%h ack0=%b ack1=%b, want 02 ack0=0 ack1=1", res, ack0, ack1);
    end
    req1 = 0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    req0 = 1; in0 = 8'hF0; shamt0 = 3'd4; dir0 = 0;
    req1 = 1; in1 = 8'h0F; shamt1 = 3'd4; dir1 = 1;
    for (int i = 0; i < 4; i++) begin
      repeat (2) @(negedge clk);
      tests++;
      if ({ack1, ack0, res} !== (i % 2 == 0 ? {2'b01, 8'h0F} : {2'b10, 8'hF0})) begin
        fails++;
        $display("FAIL rr_op%0d: got ack1=%b ack0=%b res=%h, want %s", i, ack1, ack0, res, i % 2 == 0 ? "ack0 res=0F" : "ack1 res=F0");
      end
      @(negedge clk);
      tests++;
      if ({ack1, ack0, busy} !== 3'b000) begin
        fails++;
        $display("FAIL rr_gap%0d: got ack=%b%b busy=%b, want 000", i, ack1, ack0, busy);
      end
    end
    req0 = 0; req1 = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_fixed_prio();
    b_req0 = 1; b_in0 = 8'hF0; b_shamt0 = 3'd4; b_dir0 = 0;
    b_req1 = 1; b_in1 = 8'h0F; b_shamt1 = 3'd4; b_dir1 = 1;
    for (int i = 0; i < 4; i++) begin
      repeat (2) @(negedge clk);
      tests++;
      if ({b_ack1, b_ack0, b_res} !== (i < 3 ? {2'b01, 8'h0F} : {2'b10, 8'hF0})) begin
        fails++;
        $display("FAIL fp_op%0d: got ack1=%b ack0=%b res=%h, want %s", i, b_ack1, b_ack0, b_res, i < 3 ? "ack0 res=0F" : "ack1 res=F0");
      end
      @(negedge clk);
      if (i == 2) b_req0 = 0;
    end
    b_req1 = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_operand_change();
    req0 = 1; in0 = 8'h01; shamt0 = 3'd7; dir0 = 1;
    @(negedge clk);
    in0 = 8'hFF;
    tests++;
    if (sh_in !== 8'h01) begin
      fails++;
      $display("FAIL opchg_hold: got sh_in=%h, want 01", sh_in);
    end
    @(negedge clk);
    tests++;
    if ({ack0, res} !== {1'b1, 8'h80}) begin
      fails++;
      $display("FAIL opchg_res: got ack0=%b res=%h, want ack0=1 res=80", ack0, res);
    end
    req0 = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    req1 = 1; in1 = 8'h3C; shamt1 = 3'd2; dir1 = 0;
    @(negedge clk);
    tests++;
    if ({busy, sh_in} !== {1'b1, 8'h3C}) begin
      fails++;
      $display("FAIL abort_exec: got busy=%b sh_in=%h, want busy=1 sh_in=3C", busy, sh_in);
    end
    rst = 1;
    #1;
    tests++;
    if ({ack0, ack1, busy, res, sh_in, sh_shamt, sh_dir} !== 22'h0) begin
      fails++;
      $display("FAIL abort_async: got ack=%b%b busy=%b res=%h sh=%h/%0d/%b, want all 0", ack1, ack0, busy, res, sh_in, sh_shamt, sh_dir);
    end
    @(negedge clk);
    tests++;
    if ({ack0, ack1, busy, res} !== 11'h0) begin
      fails++;
      $display("FAIL abort_noack: got ack=%b%b busy=%b res=%h, want all 0", ack1, ack0, busy, res);
    end
    rst = 0;
    @(negedge clk);
    tests++;
    if ({busy, sh_in, sh_shamt, sh_dir} !== {1'b1, 8'h3C, 3'd2, 1'b0}) begin
      fails++;
      $display("FAIL abort_regrant: got busy=%b sh=%h/%0d/%b, want busy=1 3C/2/0", busy, sh_in, sh_shamt, sh_dir);
    end
    @(negedge clk);
    tests++;
    if ({ack1, ack0, res} !== {2'b10, 8'h0F}) begin
      fails++;
      $display("FAIL abort_ack: got ack1=%b ack0=%b res=%h, want ack1=1 ack0=0 res=0F", ack1, ack0, res);
    end
    req1 = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_right_shift();
    test_left_shift();
    test_round_robin();
    test_fixed_prio();
    test_operand_change();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/shifter_arbiter.md
Name: shifter_arbiter

Overview:
- Sequential controller that shares one 8-bit combinational barrel shifter between two requesters.
- Arbitrates requests round-robin or fixed-priority and drives the shifter's operand inputs from registers.
- Captures the shifter output into a result register and returns it with a one-cycle acknowledge.
- Sits between the requesting units and a single barrel_shifter instance placed beside it at the parent level.

Parameters:
- WIDTH, 8, data width; must match the shifter.
- SHAMT_W, 3, shift-amount width; must match the shifter.
- FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = requester 0 always wins ties.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 request; level, held until ack0.
- in0  input  WIDTH  requester 0 operand.
- shamt0  input  SHAMT_W  requester 0 shift amount.
- dir0  input  1  requester 0 direction: 0 = logical right, 1 = logical left.
- req1, in1, shamt1, dir1  input  1/WIDTH/SHAMT_W/1  requester 1 equivalents.
- ack0  output  1  one-cycle pulse; res valid for requester 0.
- ack1  output  1  one-cycle pulse; res valid for requester 1.
- res  output  WIDTH  registered shift result.
- busy  output  1  high whenever state is not IDLE.
- sh_in  output  WIDTH  registered operand to the shared shifter.
- sh_shamt  output  SHAMT_W  registered shift amount to the shifter.
- sh_dir  output  1  registered direction to the shifter.
- sh_out  input  WIDTH  combinational result from the shifter.

Behaviour:
- Reset (async, rst=1): state=IDLE, ack0=ack1=0, res=0, busy=0, sh_in=0, sh_shamt=0, sh_dir=0. Last-grant pointer=1, so requester 0 wins first.
- Reset asserted mid-operation aborts immediately. No ack is issued for the aborted operation. Requesters must re-request after reset.
- States: IDLE -> EXEC -> DONE -> IDLE.
- IDLE, no request: stay in IDLE.
- IDLE, any req high at an edge:
  - grant one requester;
  - latch that requester's in/shamt/dir into sh_in/sh_shamt/sh_dir;
  - record the grant id;
  - go to EXEC.
- EXEC: sh_out settles during this cycle. At the next edge, res <= sh_out, assert ack for the granted id, go to DONE.
- DONE: ack is high for exactly this cycle. At the next edge, ack drops and state returns to IDLE.
- Latency: req sampled at edge k -> res/ack valid in the cycle after edge k+1. Throughput is one operation per 3 cycles.
- Arbitration, single request: a single request is granted regardless of mode.
- Arbitration, both requests with FIXED_PRIO=0: grant the requester not granted last. The pointer updates only on a grant.
- Arbitration, both requests with FIXED_PRIO=1: grant requester 0.
- Handshake:
  - Requester holds req and operands stable until it sees its ack.
  - Requester deasserts req on the edge ending the ack cycle.
  - A req still high in IDLE after DONE is treated as a new request.
- Operand changes on the granted port after the IDLE grant edge have no effect; sh_* are registered.
- The losing requester's req may stay high throughout. It is granted at the next IDLE evaluation.
- sh_* hold their last values in every state except at a grant. res holds until the next capture.
- ack0 and ack1 are never high simultaneously.
- No arithmetic is performed in this block. Widths pass through unchanged. Shift semantics (zero fill, shamt 0..7) belong to the shifter.

Test Plan:
- Reset, then req0=1, in0=8'hB4, shamt0=3'd2, dir0=0 -> sh_in=8'hB4 after the grant edge; ack0 pulses one cycle later with res=8'h2D; busy high for 2 cycles.
- Single left shift: req1=1, in1=8'h81, shamt1=3'd1, dir1=1 -> ack1 with res=8'h02; ack0 stays 0.
- Both requesting continuously with FIXED_PRIO=0 -> ack sequence 0,1,0,1 at 3-cycle spacing. Use distinct operands (0: 8'hF0 right 4 -> 8'h0F; 1: 8'h0F left 4 -> 8'hF0).
- FIXED_PRIO=1 with both requesting -> requester 0 served each time it requests; requester 1 served only when req0=0.
- Change in0 to 8'hFF during EXEC after granting 8'h01 with left shift 7 -> res=8'h80.
- Assert rst during EXEC -> all outputs 0 immediately, no ack. After release, a pending req1 is granted from IDLE.
